// File: rtl/writeback_if.sv
// Upstream handshake and load-data bus into the writeback stage.
interface writeback_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [31:0] in_alu_result;
  logic        in_is_load;
  logic [2:0]  in_load_fmt;
  logic        in_is_link;
  logic [31:0] in_pc;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;

  modport master (
    output in_valid, in_rd, in_reg_write, in_alu_result, in_is_load,
           in_load_fmt, in_is_link, in_pc, mem_rdata_valid, mem_rdata,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rd, in_reg_write, in_alu_result, in_is_load,
           in_load_fmt, in_is_link, in_pc, mem_rdata_valid, mem_rdata,
    output in_ready
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: waits for load data, extracts/extends it, and issues a one-cycle
// register file commit. Optional macro WB_ZERO_GUARD_EN suppresses writes to x0.
module writeback_stage #(
  parameter int NUM_REGS     = 21,
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_W        = 5
) (
  input  logic        clk,
  input  logic        rst,
  writeback_if.slave  up,
  output logic [4:0]  rd,
  output logic [31:0] rd_value,
  output logic        register_write,
  output logic        get_counter,
  output logic [31:0] current_PC,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_value,
  output logic        load_err,
  output logic [31:0] retire_count
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, COMMIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  logic [4:0]       rd_p0;
  logic             we_p0;
  logic [1:0]       off_p0;
  logic [2:0]       fmt_p0;
  logic [31:0]      pc_p0;

  function automatic logic fmt_legal(input logic [2:0] fmt);
    return fmt inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  endfunction

  function automatic logic write_ok(input logic [4:0] r, input logic we);
    logic ok;
    ok = we && (int'(r) < NUM_REGS);
`ifdef WB_ZERO_GUARD_EN
    ok = ok && (r != 5'd0);
`endif
    return ok;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [2:0]  fmt,
                                               input logic [1:0]  off);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        v;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (fmt)
      3'b000:  v = {{24{b[7]}}, b};
      3'b001:  v = {{16{h[15]}}, h};
      3'b010:  v = word;
      3'b100:  v = {24'd0, b};
      3'b101:  v = {16'd0, h};
      default: v = '0;
    endcase
    return v;
  endfunction

  assign up.in_ready = (state != LOAD_WAIT);
  assign accept      = up.in_valid && up.in_ready;

  // p0: pending-load fields, held while waiting for memory
  always_ff @(posedge clk) begin
    if (accept && up.in_is_load) begin
      rd_p0  <= up.in_rd;
      we_p0  <= up.in_reg_write;
      off_p0 <= up.in_alu_result[1:0];
      fmt_p0 <= up.in_load_fmt;
      pc_p0  <= up.in_pc;
    end
  end

  // Commit stage: control FSM and registered register-file outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      rd             <= '0;
      rd_value       <= '0;
      register_write <= 1'b0;
      get_counter    <= 1'b0;
      current_PC     <= '0;
      load_err       <= 1'b0;
      retire_count   <= '0;
    end else begin
      register_write <= 1'b0;
      get_counter    <= 1'b0;
      case (state)
        IDLE, COMMIT: begin
          if (up.in_valid) begin
            if (up.in_is_load) begin
              cnt   <= '0;
              state <= LOAD_WAIT;
            end else begin
              rd             <= up.in_rd;
              rd_value       <= up.in_alu_result;
              current_PC     <= up.in_pc;
              get_counter    <= up.in_is_link;
              register_write <= write_ok(up.in_rd, up.in_reg_write);
              retire_count   <= retire_count + 32'd1;
              state          <= COMMIT;
            end
          end else begin
            state <= IDLE;
          end
        end
        LOAD_WAIT: begin
          if (up.mem_rdata_valid) begin
            rd             <= rd_p0;
            rd_value       <= extract_load(up.mem_rdata, fmt_p0, off_p0);
            current_PC     <= pc_p0;
            register_write <= write_ok(rd_p0, we_p0) && fmt_legal(fmt_p0);
            if (!fmt_legal(fmt_p0)) load_err <= 1'b1;
            retire_count   <= retire_count + 32'd1;
            state          <= COMMIT;
          end else if (cnt == CNT_W'(LOAD_TIMEOUT - 1)) begin
            // abandoned load never reaches the register file
            load_err <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fwd_valid = register_write && (rd != 5'd0);
  assign fwd_rd    = rd;
  assign fwd_value = get_counter ? (current_PC + 32'd1) : rd_value;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized self-checking bench for writeback_stage against a transaction-level model.
module tb_writeback_stage;
  localparam int NUM_REGS     = 21;
  localparam int LOAD_TIMEOUT = 16;
  localparam int CNT_W        = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd;
  logic [31:0] rd_value;
  logic        register_write;
  logic        get_counter;
  logic [31:0] current_PC;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_value;
  logic        load_err;
  logic [31:0] retire_count;

  writeback_if wb();

  writeback_stage #(
    .NUM_REGS(NUM_REGS), .LOAD_TIMEOUT(LOAD_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .up(wb),
    .rd(rd), .rd_value(rd_value), .register_write(register_write),
    .get_counter(get_counter), .current_PC(current_PC),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_value(fwd_value),
    .load_err(load_err), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  int unsigned m_retire;
  logic        m_err;
  int          last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Byte/half/word selection from the spec rules, using shifts and modulo arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input int fmt, input int off);
    longint w;
    longint v;
    w = longint'({32'd0, word});
    case (fmt)
      0, 4: begin
        v = (w >> (8 * off)) % 256;
        if (fmt == 0 && v >= 128) v = v - 256;
      end
      1, 5: begin
        v = (w >> ((off >= 2) ? 16 : 0)) % 65536;
        if (fmt == 1 && v >= 32768) v = v - 65536;
      end
      default: v = w;
    endcase
    return v[31:0];
  endfunction

  function automatic logic exp_write(input int r, input logic we);
    logic ok;
    ok = we && (r < NUM_REGS);
`ifdef WB_ZERO_GUARD_EN
    ok = ok && (r != 0);
`endif
    return ok;
  endfunction

  task automatic expect_commit(input string tag, input int r, input logic we, input logic link,
                               input logic [31:0] val, input logic [31:0] pc, input logic legal);
    logic rw;
    m_retire++;
    if (!legal) m_err = 1'b1;
    rw = exp_write(r, we) && legal;
    check({tag, ".rw"},  32'(register_write), 32'(rw));
    check({tag, ".rd"},  32'(rd), 32'(r));
    check({tag, ".frd"}, 32'(fwd_rd), 32'(r));
    check({tag, ".gc"},  32'(get_counter), 32'(link));
    check({tag, ".fv"},  32'(fwd_valid), 32'(rw && (r != 0)));
    if (link) begin
      check({tag, ".pc"},   current_PC, pc);
      check({tag, ".fval"}, fwd_value, pc + 32'd1);
    end
    if (legal) check({tag, ".val"}, rd_value, val);
    if (legal && !link) check({tag, ".fval"}, fwd_value, val);
    check({tag, ".ret"}, retire_count, m_retire);
    check({tag, ".err"}, 32'(load_err), 32'(m_err));
  endtask

  task automatic send(input int r, input logic we, input logic [31:0] alu, input logic is_load,
                      input int fmt, input logic link, input logic [31:0] pc, input int delay,
                      input logic [31:0] mem, input logic noise);
    logic legal;
    check("accept.ready", 32'(wb.in_ready), 32'd1);
    wb.in_valid        = 1'b1;
    wb.in_rd           = 5'(r);
    wb.in_reg_write    = we;
    wb.in_alu_result   = alu;
    wb.in_is_load      = is_load;
    wb.in_load_fmt     = 3'(fmt);
    wb.in_is_link      = link;
    wb.in_pc           = pc;
    wb.mem_rdata_valid = noise;
    wb.mem_rdata       = $urandom;
    tick;
    wb.in_valid        = 1'b0;
    wb.mem_rdata_valid = 1'b0;
    if (is_load) begin
      for (int i = 0; i < delay; i++) begin
        check("wait.ready", 32'(wb.in_ready), 32'd0);
        check("wait.rw", 32'(register_write), 32'd0);
        tick;
      end
      check("data.ready", 32'(wb.in_ready), 32'd0);
      wb.mem_rdata_valid = 1'b1;
      wb.mem_rdata       = mem;
      tick;
      wb.mem_rdata_valid = 1'b0;
      legal = (fmt == 0 || fmt == 1 || fmt == 2 || fmt == 4 || fmt == 5);
      expect_commit("load", r, we, 1'b0, ref_load(mem, fmt, int'(alu[1:0])), pc, legal);
    end else begin
      expect_commit("alu", r, we, link, alu, pc, 1'b1);
    end
    last_rd = r;
  endtask

  task automatic idle_check;
    wb.in_valid = 1'b0;
    tick;
    check("idle.rw", 32'(register_write), 32'd0);
    check("idle.fv", 32'(fwd_valid), 32'd0);
    check("idle.gc", 32'(get_counter), 32'd0);
    check("idle.rd", 32'(rd), 32'(last_rd));
    check("idle.ready", 32'(wb.in_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;
    int fmts[8] = '{0, 1, 2, 4, 5, 3, 6, 7};

    rst = 1'b1;
    wb.in_valid = 1'b0; wb.in_rd = '0; wb.in_reg_write = 1'b0; wb.in_alu_result = '0;
    wb.in_is_load = 1'b0; wb.in_load_fmt = '0; wb.in_is_link = 1'b0; wb.in_pc = '0;
    wb.mem_rdata_valid = 1'b0; wb.mem_rdata = '0;
    m_retire = 0; m_err = 1'b0; last_rd = 0;
    #12;
    check("rst.ready", 32'(wb.in_ready), 32'd1);
    check("rst.rw", 32'(register_write), 32'd0);
    check("rst.rd", 32'(rd), 32'd0);
    check("rst.val", rd_value, 32'd0);
    check("rst.gc", 32'(get_counter), 32'd0);
    check("rst.pc", current_PC, 32'd0);
    check("rst.fv", 32'(fwd_valid), 32'd0);
    check("rst.err", 32'(load_err), 32'd0);
    check("rst.ret", retire_count, 32'd0);
    rst = 1'b0;
    tick;

    send(5, 1'b1, 32'h0000_1234, 1'b0, 0, 1'b0, 32'h10, 0, 0, 1'b0);
    check("first.val", rd_value, 32'h0000_1234);
    idle_check;

    send(1, 1'b1, 32'h111, 1'b0, 0, 1'b0, 32'h20, 0, 0, 1'b0);
    send(2, 1'b1, 32'h222, 1'b0, 0, 1'b0, 32'h21, 0, 0, 1'b0);
    send(3, 1'b1, 32'h333, 1'b0, 0, 1'b0, 32'h22, 0, 0, 1'b0);
    idle_check;

    send(7, 1'b1, 32'h0000_0102, 1'b1, 0, 1'b0, 32'h30, 3, 32'h0080_FF00, 1'b1);
    check("lb.val", rd_value, 32'hFFFF_FF80);
    send(8, 1'b1, 32'h0000_0102, 1'b1, 4, 1'b0, 32'h31, 1, 32'h0080_FF00, 1'b0);
    check("lbu.val", rd_value, 32'h0000_0080);
    send(9, 1'b1, 32'h0000_0103, 1'b1, 1, 1'b0, 32'h32, 2, 32'h0080_FF00, 1'b1);
    check("lh.val", rd_value, 32'h0000_0080);
    idle_check;

    send(1, 1'b1, 32'h0, 1'b0, 0, 1'b1, 32'h40, 0, 0, 1'b0);
    check("link.fval", fwd_value, 32'h41);
    send(25, 1'b1, 32'hAB, 1'b0, 0, 1'b0, 32'h50, 0, 0, 1'b0);
    send(0, 1'b1, 32'hCD, 1'b0, 0, 1'b0, 32'h51, 0, 0, 1'b0);
    idle_check;

    // load that never receives data
    check("to.accept", 32'(wb.in_ready), 32'd1);
    wb.in_valid = 1'b1; wb.in_rd = 5'd4; wb.in_reg_write = 1'b1; wb.in_is_load = 1'b1;
    wb.in_load_fmt = 3'd2; wb.in_alu_result = 32'h200;
    tick;
    wb.in_valid = 1'b0;
    n = 0; seen = 1'b0;
    while (wb.in_ready == 1'b0 && n < 40) begin
      seen = seen | register_write;
      n++;
      tick;
    end
    m_err = 1'b1;
    check("to.cycles", 32'(n), 32'(LOAD_TIMEOUT));
    check("to.rw", 32'(seen | register_write), 32'd0);
    check("to.err", 32'(load_err), 32'd1);
    check("to.ret", retire_count, m_retire);
    send(6, 1'b1, 32'h66, 1'b0, 0, 1'b0, 32'h60, 0, 0, 1'b0);

    // reset while a load is pending
    wb.in_valid = 1'b1; wb.in_rd = 5'd10; wb.in_is_load = 1'b1; wb.in_load_fmt = 3'd2;
    tick;
    wb.in_valid = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    #1;
    check("mrst.ready", 32'(wb.in_ready), 32'd1);
    check("mrst.rw", 32'(register_write), 32'd0);
    check("mrst.ret", retire_count, 32'd0);
    check("mrst.err", 32'(load_err), 32'd0);
    #2;
    rst = 1'b0;
    m_retire = 0; m_err = 1'b0; last_rd = 0;
    wb.mem_rdata_valid = 1'b1; wb.mem_rdata = 32'hDEAD_BEEF;
    tick;
    wb.mem_rdata_valid = 1'b0;
    check("mrst.late_rw", 32'(register_write), 32'd0);
    check("mrst.late_ret", retire_count, 32'd0);

    send(11, 1'b1, 32'h0000_0001, 1'b1, 3, 1'b0, 32'h70, 1, 32'h1234_5678, 1'b0);
    idle_check;

    for (int t = 0; t < 200; t++) begin
      logic ld;
      int   f;
      ld = ($urandom_range(0, 9) < 4);
      f  = ($urandom_range(0, 9) == 0) ? fmts[$urandom_range(5, 7)] : fmts[$urandom_range(0, 4)];
      send(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom, ld, f,
           (!ld) && ($urandom_range(0, 4) == 0), $urandom, int'($urandom_range(0, 5)),
           $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_check;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
